// File: rtl/unsigned_approx_mult_pipe_pkg.sv
// Shared definitions for the truncated-row approximate multiplier.
// Provides the parameter legality check and the C-term column mask.
package unsigned_approx_mult_pipe_pkg;

    // Widest operand supported. The column mask is sized to cover 2*MaxW columns.
    localparam int unsigned MaxW = 32;
    localparam int unsigned MaskBits = 2 * MaxW;

    typedef logic [MaskBits-1:0] col_mask_t;

    // Returns 1 when (w, t) is a supported configuration.
    function automatic bit params_legal(input int unsigned w, input int unsigned t);
        return (w >= 4) && (w <= MaxW) && (t < w);
    endfunction

    // Columns whose partial-product bits from the truncated rows are kept in C.
    // Rows i < t contribute to columns w-1 .. w+t-2.
    function automatic col_mask_t c_col_mask(input int unsigned w, input int unsigned t);
        col_mask_t m;
        m = '0;
        for (int unsigned k = 0; k < MaskBits; k++) begin
            if ((t > 0) && (k >= w - 1) && (k <= w + t - 2)) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/unsigned_approx_mult_pipe_if.sv
// Operand/result handshake bundle for the approximate multiplier pipeline.
interface unsigned_approx_mult_pipe_if #(
    parameter int unsigned W = 8
);
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           approx_en;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] z;
    logic           z_approx;

    // Producer/consumer side (drives operands, accepts results).
    modport master (
        output flush, in_valid, x, y, approx_en, out_ready,
        input  in_ready, out_valid, z, z_approx
    );

    // Multiplier side.
    modport slave (
        input  flush, in_valid, x, y, approx_en, out_ready,
        output in_ready, out_valid, z, z_approx
    );
endinterface

// File: rtl/unsigned_approx_mult_pipe_approx_pp_trunc.sv
// Combinational partial-product stage: produces the (possibly truncated) main
// product and the C correction term. In exact mode C is zero and the main
// product is the full x*y.
module approx_pp_trunc
    import unsigned_approx_mult_pipe_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned T = 2
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic           approx_en,
    output logic [2*W-1:0] trunc_prod,
    output logic [2*W-1:0] c_term
);
    localparam int unsigned PW = 2 * W;
    localparam col_mask_t   CMask = c_col_mask(W, T);

    logic [PW-1:0] full_prod;
    logic [PW-1:0] upper_prod;
    logic [PW-1:0] c_sum;

    // Main product: full, or only rows T..W-1 shifted back into place.
    always_comb begin
        full_prod  = PW'(x) * PW'(y);
        upper_prod = (PW'(y) * PW'(x >> T)) << T;
        trunc_prod = approx_en ? upper_prod : full_prod;
    end

    // C term: surviving partial-product bits of the dropped rows, summed exactly.
    always_comb begin
        c_sum = '0;
        for (int i = 0; i < int'(T); i++) begin
            for (int j = 0; j < int'(W); j++) begin
                if (CMask[i+j]) begin
                    c_sum = c_sum + (PW'(x[i] & y[j]) << (i + j));
                end
            end
        end
        c_term = approx_en ? c_sum : '0;
    end

endmodule

// File: rtl/unsigned_approx_mult_pipe.sv
// Two-stage valid/ready pipeline around the approximate multiplier.
// S1 holds the main product and C; S2 holds the final sum z and its mode flag.
module unsigned_approx_mult_pipe
    import unsigned_approx_mult_pipe_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned T = 2
) (
    input logic                           clk,
    input logic                           rst_n,
    unsigned_approx_mult_pipe_if.slave    bus
);
    localparam int unsigned PW = 2 * W;

    if (!params_legal(W, T)) begin : g_bad_params
        $error("unsigned_approx_mult_pipe: illegal W/T combination");
    end

    logic [PW-1:0] trunc_prod;
    logic [PW-1:0] c_term;

    logic          s1_valid;
    logic [PW-1:0] s1_trunc;
    logic [PW-1:0] s1_c;
    logic          s1_approx;

    logic          s2_valid;
    logic [PW-1:0] z_q;
    logic          z_approx_q;

    logic          s1_ready;
    logic          s2_ready;
    logic          accept;

    approx_pp_trunc #(
        .W (W),
        .T (T)
    ) u_pp (
        .x          (bus.x),
        .y          (bus.y),
        .approx_en  (bus.approx_en),
        .trunc_prod (trunc_prod),
        .c_term     (c_term)
    );

    // Stage enables; in_ready is gated by reset and flush but never by in_valid.
    always_comb begin
        s2_ready     = !s2_valid || bus.out_ready;
        s1_ready     = !s1_valid || s2_ready;
        bus.in_ready = s1_ready && !bus.flush && rst_n;
        accept       = bus.in_valid && bus.in_ready;
    end

    // Control and output registers; flush clears valids and wins over a transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            z_q        <= '0;
            z_approx_q <= 1'b0;
        end else if (bus.flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_ready) begin
                s1_valid <= accept;
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    z_q        <= s1_trunc + s1_c;
                    z_approx_q <= s1_approx;
                end
            end
        end
    end

    // S1 datapath registers load only on an accepted transfer.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_trunc  <= trunc_prod;
            s1_c      <= c_term;
            s1_approx <= bus.approx_en;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.z         = z_q;
    assign bus.z_approx  = z_approx_q;

endmodule

// File: tb/tb_unsigned_approx_mult_pipe.sv
// Directed bench for unsigned_approx_mult_pipe at W=8, T=2.
module tb_unsigned_approx_mult_pipe;
    localparam int unsigned W = 8;
    localparam int unsigned T = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    unsigned_approx_mult_pipe_if #(.W(W)) bus ();

    unsigned_approx_mult_pipe #(
        .W (W),
        .T (T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: sum every partial product that survives the mode's truncation rule.
    function automatic logic [16:0] golden(input logic [7:0] a, input logic [7:0] b,
                                           input logic ae);
        int unsigned acc;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (a[i] && b[j] && (!ae || i >= int'(T) || i + j >= int'(W) - 1)) begin
                    acc += 32'd1 << (i + j);
                end
            end
        end
        return {ae, acc[15:0]};
    endfunction

    // One isolated transfer; result must appear exactly two cycles later.
    task automatic one_shot(input logic [7:0] a, input logic [7:0] b, input logic ae,
                            input logic [15:0] exp_z, input logic exp_a, input string tag);
        @(negedge clk);
        bus.x = a;
        bus.y = b;
        bus.approx_en = ae;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_early_valid"}, 64'(bus.out_valid), 0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(bus.out_valid), 1);
        check({tag, "_z"}, 64'(bus.z), 64'(exp_z));
        check({tag, "_z_approx"}, 64'(bus.z_approx), 64'(exp_a));
        @(negedge clk);
        check({tag, "_drained"}, 64'(bus.out_valid), 0);
    endtask

    logic [16:0] expq[$];
    logic [16:0] e;
    int sent;
    int got;
    int cyc;
    logic held_valid;
    logic [15:0] held_z;
    logic held_za;

    initial begin
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.approx_en = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_z", 64'(bus.z), 0);
        check("rst_z_approx", 64'(bus.z_approx), 0);
        check("rst_in_ready", 64'(bus.in_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 1);
        check("post_rst_out_valid", 64'(bus.out_valid), 0);

        // Hand-computed vectors
        one_shot(8'hFF, 8'hFF, 1'b1, 16'd64772, 1'b1, "ff_ff_approx");
        one_shot(8'hFF, 8'hFF, 1'b0, 16'd65025, 1'b0, "ff_ff_exact");
        one_shot(8'h03, 8'h80, 1'b1, 16'd384, 1'b1, "03_80_approx");
        one_shot(8'h03, 8'h80, 1'b0, 16'd384, 1'b0, "03_80_exact");
        one_shot(8'h01, 8'h7F, 1'b1, 16'd0, 1'b1, "01_7f_approx");
        one_shot(8'h01, 8'h7F, 1'b0, 16'd127, 1'b0, "01_7f_exact");
        one_shot(8'h0C, 8'h0A, 1'b1, 16'd120, 1'b1, "0c_0a_approx");

        // Random stream with random back-pressure
        sent = 0;
        got = 0;
        cyc = 0;
        held_valid = 1'b0;
        held_z = '0;
        held_za = 1'b0;
        while (got < 16 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (held_valid) begin
                check("stall_valid", 64'(bus.out_valid), 1);
                check("stall_z", 64'(bus.z), 64'(held_z));
                check("stall_z_approx", 64'(bus.z_approx), 64'(held_za));
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            if (sent < 16) begin
                bus.in_valid = 1'b1;
                bus.x = 8'($urandom);
                bus.y = 8'($urandom);
                bus.approx_en = 1'($urandom_range(0, 1));
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            held_valid = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                check("stream_pending", 64'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check("stream_z", 64'(bus.z), 64'(e[15:0]));
                    check("stream_z_approx", 64'(bus.z_approx), 64'(e[16]));
                    got++;
                end
            end else if (bus.out_valid) begin
                held_valid = 1'b1;
                held_z = bus.z;
                held_za = bus.z_approx;
            end
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(golden(bus.x, bus.y, bus.approx_en));
                sent++;
            end
        end
        check("stream_count", 64'(got), 16);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("stream_idle", 64'(bus.out_valid), 0);

        // Reset with two results in flight
        bus.out_ready = 1'b0;
        bus.x = 8'h11;
        bus.y = 8'h22;
        bus.approx_en = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.x = 8'h33;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("inflight_full", 64'(bus.out_valid), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(bus.out_valid), 0);
        check("midrst_in_ready", 64'(bus.in_ready), 0);
        check("midrst_z", 64'(bus.z), 0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_no_stale", 64'(bus.out_valid), 0);
        end

        // Flush with a simultaneous transfer request: request is dropped
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.x = 8'h05;
        bus.y = 8'h05;
        #1;
        check("flush_in_ready", 64'(bus.in_ready), 0);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("flush_dropped", 64'(bus.out_valid), 0);
        end

        // Flush while a result sits in S1
        bus.in_valid = 1'b1;
        bus.x = 8'h07;
        bus.y = 8'h09;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("flush_inflight", 64'(bus.out_valid), 0);
            @(negedge clk);
        end

        one_shot(8'h10, 8'h10, 1'b0, 16'd256, 1'b0, "after_flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
